overture_sequencer: RTL
=======================

# overture_sequencer

Instruction sequencer and branch resolver for the Overture 8-bit CPU. It owns the program counter and fetches instruction bytes over a request/acknowledge port. It resolves condition-class instructions internally, using the Overture 3-bit condition code against REG3, with REG0 as the jump target. All other instructions go to the datapath over a valid/ready handshake.

## Interface
Parameters:
- UUID, 0, instance identifier (no functional effect)
- NAME, "", instance name (no functional effect)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- run  in  1  level enable; sampled whenever the FSM is about to enter FETCH
- fetch_req  out  1  instruction fetch request, held until acknowledged
- fetch_addr  out  8  fetch address (= pc)
- fetch_ack  in  1  memory acknowledge; fetch_data valid in same cycle
- fetch_data  in  8  instruction byte
- reg0  in  8  current REG0 (jump target)
- reg3  in  8  current REG3 (condition operand)
- exec_valid  out  1  non-condition instruction offered to datapath
- exec_instr  out  8  instruction byte offered (= ir)
- exec_ready  in  1  datapath accepts exec_instr
- halted  out  1  sequencer stopped on self-jump
- taken_count  out  8  saturating count of taken branches

## Operation
- Internal state: pc[7:0], ir[7:0], taken_count[7:0], FSM state {IDLE, FETCH, EVAL, ISSUE, HALT}.
- Decoded outputs:
  - fetch_req = (state==FETCH)
  - fetch_addr = pc
  - exec_valid = (state==ISSUE)
  - exec_instr = ir
  - halted = (state==HALT)
- Condition instruction: ir[7:6]==2'b11, with code c = ir[2:0].
  - taken = ((c[0] & reg3==0) | (c[1] & reg3[7])) ^ c[2]
  - Code map: 000 never, 001 ==0, 010 <0, 011 <=0, 100 always, 101 !=0, 110 >=0, 111 >0 (signed 8-bit).
  - ir[5:3] are ignored.
- IDLE:
  - run=1 → FETCH.
  - run=0 → stay in IDLE.
- FETCH:
  - fetch_ack=1 → ir<=fetch_data, go to EVAL.
  - Otherwise hold fetch_req=1 and fetch_addr stable.
  - run is not re-checked in this state; an outstanding request is never abandoned.
- EVAL: reg0 and reg3 are sampled in this cycle.
  - Non-condition instruction → ISSUE.
  - Condition instruction, taken, reg0==pc → HALT. pc is unchanged; taken_count still increments.
  - Condition instruction, taken, reg0!=pc → pc<=reg0, taken_count increments, next state is FETCH if run else IDLE.
  - Condition instruction, not taken → pc<=pc+1, next state is FETCH if run else IDLE.
- ISSUE:
  - exec_valid=1.
  - exec_valid and exec_instr must not change while exec_ready=0.
  - On exec_ready=1: pc<=pc+1, next state is FETCH if run else IDLE.
- HALT:
  - Absorbing state; only rst exits.
  - No fetch and no exec activity.
- pc arithmetic is modulo 256: 0xFF+1 → 0x00.
- taken_count saturates at 0xFF and never wraps.

## Timing
- Reset: asynchronous. On rst assertion, without waiting for a clock edge:
  - state=IDLE
  - pc, ir, taken_count = 0x00
  - fetch_req, exec_valid, halted = 0
  - fetch_addr = 0x00, exec_instr = 0x00
- First fetch: with run=1 at the first edge after rst deasserts, fetch_req rises one cycle later.
- Fetch latency: fetch_req asserted in cycle N with fetch_ack=1 in cycle N means EVAL in N+1.
- Minimum throughput (zero-wait ack and ready):
  - Condition instruction: 2 cycles.
  - Other instructions: 3 cycles.
- A new fetch_addr is visible in the first FETCH cycle after the pc update.
- fetch_ack or exec_ready asserted outside its matching state is ignored.
- rst asserted mid-transaction (any state) aborts immediately. No partial pc or taken_count update survives.

## Test plan
- Straight-line code:
  - Stimulus: reset, run=1, fetch_data=0x05 with immediate ack, exec_ready=1.
  - Response: fetch_addr 0x00, exec_valid with exec_instr=0x05, then fetch_addr 0x01. Instructions complete every 3 cycles.
- Conditional branch on 0xC1 (==0) at pc=0x02, reg0=0x40:
  - reg3=0x00 → next fetch_addr=0x40, taken_count=1.
  - reg3=0x01 → next fetch_addr=0x03, taken_count unchanged.
- Condition matrix: all 8 codes × reg3 ∈ {0x00, 0x80, 0x7F}.
  - Taken must match the code map, e.g. code 111: only 0x7F taken; code 011: 0x00 and 0x80 taken.
- Wrap-around and backpressure:
  - pc=0xFF with non-taken 0xC0 → next fetch_addr=0x00.
  - exec_ready held 0 for 5 cycles → exec_valid and exec_instr stable, pc unchanged.
- Halt and saturation:
  - 0xC4 with reg0==pc → halted=1, fetch_req stays 0 indefinitely.
  - 300 taken branches → taken_count=0xFF.
- Async reset:
  - Stimulus: rst pulsed between clock edges while in ISSUE with exec_ready=0.
  - Response: exec_valid, halted, pc and taken_count clear before the next edge. run=1 afterwards restarts the fetch at 0x00.

Source files
------------

// File: rtl/overture_sequencer.sv
// Overture 8-bit CPU instruction sequencer: owns the pc, fetches instruction bytes,
// resolves condition-class branches locally and hands every other instruction to the datapath.
//
// state | meaning
// IDLE  | waiting for run before the next fetch
// FETCH | fetch_req held at pc until fetch_ack
// EVAL  | decode ir; resolve branch against reg3, jump to reg0
// ISSUE | exec_valid held with ir until exec_ready
// HALT  | taken self-jump; absorbing until rst
module overture_sequencer #(
   parameter int    UUID = 0,
   parameter string NAME = ""
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   output logic       fetch_req,
   output logic [7:0] fetch_addr,
   input  logic       fetch_ack,
   input  logic [7:0] fetch_data,
   input  logic [7:0] reg0,
   input  logic [7:0] reg3,
   output logic       exec_valid,
   output logic [7:0] exec_instr,
   input  logic       exec_ready,
   output logic       halted,
   output logic [7:0] taken_count
);

   localparam int    unused_uuid = UUID;
   localparam string unused_name = NAME;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EVAL,
      ST_ISSUE,
      ST_HALT
   } state_t;

   state_t     state_q;
   state_t     resume_d;
   logic [7:0] pc_q;
   logic [7:0] ir_q;
   logic [7:0] taken_q;
   logic [7:0] taken_d;
   logic [2:0] code;
   logic       is_cond;
   logic       cond_taken;

   // Code bit 0 tests zero, bit 1 tests sign, bit 2 inverts the result.
   always_comb begin
      code       = ir_q[2:0];
      is_cond    = (ir_q[7:6] == 2'b11);
      cond_taken = ((code[0] & (reg3 == 8'h00)) | (code[1] & reg3[7])) ^ code[2];
      taken_d    = (taken_q == 8'hFF) ? taken_q : taken_q + 8'd1;
      resume_d   = run ? ST_FETCH : ST_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= 8'h00;
         ir_q    <= 8'h00;
         taken_q <= 8'h00;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (run) state_q <= ST_FETCH;
            end
            ST_FETCH: begin
               if (fetch_ack) begin
                  ir_q    <= fetch_data;
                  state_q <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               if (!is_cond) begin
                  state_q <= ST_ISSUE;
               end else if (cond_taken) begin
                  taken_q <= taken_d;
                  if (reg0 == pc_q) begin
                     state_q <= ST_HALT;
                  end else begin
                     pc_q    <= reg0;
                     state_q <= resume_d;
                  end
               end else begin
                  pc_q    <= pc_q + 8'd1;
                  state_q <= resume_d;
               end
            end
            ST_ISSUE: begin
               if (exec_ready) begin
                  pc_q    <= pc_q + 8'd1;
                  state_q <= resume_d;
               end
            end
            ST_HALT: begin
               state_q <= ST_HALT;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign fetch_req   = (state_q == ST_FETCH);
   assign fetch_addr  = pc_q;
   assign exec_valid  = (state_q == ST_ISSUE);
   assign exec_instr  = ir_q;
   assign halted      = (state_q == ST_HALT);
   assign taken_count = taken_q;

endmodule
